// File: rtl/hsv_cvt_pkg.sv
// Shared constants and helpers for the RGB->HSV stream converter.
// Hue bases are given in units of SEG (one sixth of the channel range).
package hsv_cvt_pkg;

    // Hue sector bases, as multiples of SEG.
    localparam int unsigned HUE_BASE_R    = 0;
    localparam int unsigned HUE_BASE_G    = 2;
    localparam int unsigned HUE_BASE_B    = 4;
    localparam int unsigned HUE_BASE_WRAP = 6;

    // Which channel holds the maximum (ties resolved R > G > B).
    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } max_ch_e;

    function automatic int unsigned maxv_of(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int unsigned seg_of(input int unsigned w);
        return (32'd1 << w) / 32'd6;
    endfunction

    // Input register + two arithmetic stages + divider + output register.
    function automatic int unsigned lat_of(input int unsigned w);
        return w + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_div.sv
// Pipelined restoring divider: one quotient bit per stage, DATA_W stages.
// Dividend is 2*DATA_W wide and must satisfy num < den * 2^DATA_W.
// A sideband word and a valid bit travel alongside each operand pair.
module pipe_div #(
    parameter int DATA_W = 8,
    parameter int SB_W   = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_sys,
    input  logic                  vld_i,
    input  logic [2*DATA_W-1:0]   num_i,
    input  logic [DATA_W-1:0]     den_i,
    input  logic [SB_W-1:0]       sb_i,
    output logic                  vld_o,
    output logic [DATA_W-1:0]     quo_o,
    output logic [SB_W-1:0]       sb_o
);

    localparam int NW = 2 * DATA_W;

    logic              vld_q [DATA_W];
    logic [DATA_W-1:0] quo_q [DATA_W];
    logic [SB_W-1:0]   sb_q  [DATA_W];
    // The last stage needs neither remainder nor divisor afterwards.
    logic [NW-1:0]     rem_q [DATA_W-1];
    logic [DATA_W-1:0] den_q [DATA_W-1];

    for (genvar k = 0; k < DATA_W; k++) begin : g_stage
        localparam int BIT = DATA_W - 1 - k;

        logic              vld_in;
        logic [NW-1:0]     rem_in;
        logic [DATA_W-1:0] den_in;
        logic [DATA_W-1:0] quo_in;
        logic [SB_W-1:0]   sb_in;
        logic [NW-1:0]     den_sh;
        logic              ge;
        logic [DATA_W-1:0] quo_nxt;

        if (k == 0) begin : g_head
            assign vld_in = vld_i;
            assign rem_in = num_i;
            assign den_in = den_i;
            assign quo_in = '0;
            assign sb_in  = sb_i;
        end else begin : g_link
            assign vld_in = vld_q[k-1];
            assign rem_in = rem_q[k-1];
            assign den_in = den_q[k-1];
            assign quo_in = quo_q[k-1];
            assign sb_in  = sb_q[k-1];
        end

        assign den_sh = NW'(den_in) << BIT;
        assign ge     = (rem_in >= den_sh);

        // Set this stage's quotient bit on top of the bits already resolved.
        always_comb begin
            // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
            quo_nxt      = quo_in;
            quo_nxt[BIT] = ge;
        end

        // Valid chain is the only state that must be cleared.
        always_ff @(posedge clk_sys) begin
            // NOTE: sequential state uses non-blocking (<=) so every stage samples pre-edge values.
            if (reset_sys) begin
                vld_q[k] <= 1'b0;
            end else begin
                vld_q[k] <= vld_in;
            end
        end

        // Quotient and sideband advance one stage per clock.
        always_ff @(posedge clk_sys) begin
            // NOTE: datapath registers are not reset; the valid bit alone qualifies them.
            quo_q[k] <= quo_nxt;
            sb_q[k]  <= sb_in;
        end

        if (k < DATA_W - 1) begin : g_carry
            // Restoring step: subtract the shifted divisor when it fits.
            always_ff @(posedge clk_sys) begin
                rem_q[k] <= ge ? (rem_in - den_sh) : rem_in;
                den_q[k] <= den_in;
            end
        end
    end

    assign vld_o = vld_q[DATA_W-1];
    assign quo_o = quo_q[DATA_W-1];
    assign sb_o  = sb_q[DATA_W-1];

endmodule

// File: rtl/hsv_stream_cvt.sv
// RGB -> HSV video stream converter, serial (one channel per beat) or
// packed (one pixel per beat). Fixed latency DATA_W+4 from the pixel-
// completing beat to the first output; syncs are delayed to stay aligned.
// Optional partial-pixel check: define HSV_PIX_ERR_CHECK_EN.
module hsv_stream_cvt
    import hsv_cvt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SERIAL = 1
) (
    input  logic                                         clk_sys,
    input  logic                                         reset_sys,
    input  logic                                         InVSYNC,
    input  logic                                         InHSYNC,
    input  logic                                         InEN,
    input  logic [((SERIAL != 0) ? DATA_W : 3*DATA_W)-1:0] InData,
    output logic                                         OutVSYNC,
    output logic                                         OutHSYNC,
    output logic                                         OutEN,
    output logic [((SERIAL != 0) ? DATA_W : 3*DATA_W)-1:0] Outdata,
    output logic                                         pix_err
);

    localparam int          BUS_W    = (SERIAL != 0) ? DATA_W : 3 * DATA_W;
    localparam int unsigned MAXV     = maxv_of(DATA_W);
    localparam int unsigned SEG      = seg_of(DATA_W);
    localparam int unsigned L        = lat_of(DATA_W);
    localparam int          SYNC_DLY = int'(L) + ((SERIAL != 0) ? 2 : 0);

    // ---------------- pixel assembly ----------------
    logic                  sync;
    logic [1:0]            byte_cnt_q, byte_cnt_d, cnt_eff;
    logic [DATA_W-1:0]     r_q, g_q;
    logic                  pix_done;
    logic [3*DATA_W-1:0]   pix_rgb;

    assign sync = InHSYNC | InVSYNC;

    // A sync restarts assembly; a beat in the same cycle is byte 0.
    always_comb begin
        cnt_eff    = sync ? 2'd0 : byte_cnt_q;
        byte_cnt_d = cnt_eff;
        pix_done   = 1'b0;
        pix_rgb    = {r_q, g_q, InData[DATA_W-1:0]};
        if (SERIAL != 0) begin
            if (InEN) begin
                pix_done   = (cnt_eff == 2'd2);
                byte_cnt_d = (cnt_eff == 2'd2) ? 2'd0 : cnt_eff + 2'd1;
            end
        end else begin
            pix_done   = InEN;
            byte_cnt_d = 2'd0;
            pix_rgb    = (3*DATA_W)'(InData);
        end
    end

    // Byte position within the current serial pixel.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) byte_cnt_q <= 2'd0;
        else           byte_cnt_q <= byte_cnt_d;
    end

    // Hold R and G until B completes the pixel.
    always_ff @(posedge clk_sys) begin
        if (InEN && (cnt_eff == 2'd0)) r_q <= InData[DATA_W-1:0];
        if (InEN && (cnt_eff == 2'd1)) g_q <= InData[DATA_W-1:0];
    end

    // ---------------- stage A: registered pixel ----------------
    logic              a_vld_q;
    logic [DATA_W-1:0] a_r_q, a_g_q, a_b_q;

    // Capture the completed pixel.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) a_vld_q <= 1'b0;
        else           a_vld_q <= pix_done;
        {a_r_q, a_g_q, a_b_q} <= pix_rgb;
    end

    // ---------------- stage B: max/min, hue sector ----------------
    max_ch_e           max_ch;
    logic [DATA_W-1:0] mx_c, mn_c, minu_c, subt_c, absn_c, base_c;
    logic              neg_c;

    // Pick the max channel and the signed hue numerator for its sector.
    always_comb begin
        max_ch = CH_B;
        mx_c   = a_b_q;
        if ((a_r_q >= a_g_q) && (a_r_q >= a_b_q)) begin
            max_ch = CH_R;
            mx_c   = a_r_q;
        end else if (a_g_q >= a_b_q) begin
            max_ch = CH_G;
            mx_c   = a_g_q;
        end
        mn_c = a_r_q;
        if (a_g_q < mn_c) mn_c = a_g_q;
        if (a_b_q < mn_c) mn_c = a_b_q;
        minu_c = a_g_q;
        subt_c = a_b_q;
        base_c = DATA_W'(HUE_BASE_R * SEG);
        case (max_ch)
            CH_G: begin
                minu_c = a_b_q;
                subt_c = a_r_q;
                base_c = DATA_W'(HUE_BASE_G * SEG);
            end
            CH_B: begin
                minu_c = a_r_q;
                subt_c = a_g_q;
                base_c = DATA_W'(HUE_BASE_B * SEG);
            end
            default: ;
        endcase
        neg_c  = (minu_c < subt_c);
        absn_c = neg_c ? (subt_c - minu_c) : (minu_c - subt_c);
        // Negative hue in the red sector counts down from the top of the circle.
        if (neg_c && (max_ch == CH_R)) base_c = DATA_W'(HUE_BASE_WRAP * SEG);
    end

    logic              b_vld_q, b_neg_q;
    logic [DATA_W-1:0] b_mx_q, b_d_q, b_absn_q, b_base_q;

    // Register sector decode.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) b_vld_q <= 1'b0;
        else           b_vld_q <= a_vld_q;
        b_mx_q   <= mx_c;
        b_d_q    <= mx_c - mn_c;
        b_absn_q <= absn_c;
        b_neg_q  <= neg_c;
        b_base_q <= base_c;
    end

    // ---------------- stage C: dividends ----------------
    logic                c_vld_q, c_neg_q;
    logic [DATA_W-1:0]   c_mx_q, c_d_q, c_base_q;
    logic [2*DATA_W-1:0] c_snum_q, c_hnum_q;

    // Scale numerators so the quotients land directly in output units.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) c_vld_q <= 1'b0;
        else           c_vld_q <= b_vld_q;
        c_snum_q <= (2*DATA_W)'(b_d_q) * (2*DATA_W)'(MAXV);
        c_hnum_q <= (2*DATA_W)'(b_absn_q) * (2*DATA_W)'(SEG);
        c_mx_q   <= b_mx_q;
        c_d_q    <= b_d_q;
        c_neg_q  <= b_neg_q;
        c_base_q <= b_base_q;
    end

    // ---------------- dividers ----------------
    logic              ds_vld, ds_zero, dh_vld;
    logic [DATA_W-1:0] ds_quo, dh_quo;
    logic [DATA_W-1:0] o_mx, o_base;
    logic              o_neg, o_zero;

    pipe_div #(.DATA_W(DATA_W), .SB_W(1)) u_div_s (
        .clk_sys   (clk_sys),
        .reset_sys (reset_sys),
        .vld_i     (c_vld_q),
        .num_i     (c_snum_q),
        .den_i     (c_mx_q),
        .sb_i      (c_mx_q == '0),
        .vld_o     (ds_vld),
        .quo_o     (ds_quo),
        .sb_o      (ds_zero)
    );

    pipe_div #(.DATA_W(DATA_W), .SB_W(2*DATA_W+2)) u_div_h (
        .clk_sys   (clk_sys),
        .reset_sys (reset_sys),
        .vld_i     (c_vld_q),
        .num_i     (c_hnum_q),
        .den_i     (c_d_q),
        .sb_i      ({c_mx_q, c_base_q, c_neg_q, (c_d_q == '0)}),
        .vld_o     (dh_vld),
        .quo_o     (dh_quo),
        .sb_o      ({o_mx, o_base, o_neg, o_zero})
    );

    // ---------------- output stage ----------------
    logic              div_vld;
    logic [DATA_W:0]   h_sum;
    logic [DATA_W-1:0] h_val, s_val;
    logic [BUS_W-1:0]  first_word;

    assign div_vld = dh_vld & ds_vld;

    // Final hue/saturation; zero divisors force 0, a full turn wraps to 0.
    always_comb begin
        h_sum = o_neg ? ({1'b0, o_base} - {1'b0, dh_quo})
                      : ({1'b0, o_base} + {1'b0, dh_quo});
        h_val = h_sum[DATA_W-1:0];
        if (o_zero || (h_sum == (DATA_W+1)'(HUE_BASE_WRAP * SEG))) h_val = '0;
        s_val = ds_zero ? '0 : ds_quo;
    end

    assign first_word = (SERIAL != 0) ? BUS_W'(h_val) : BUS_W'({h_val, s_val, o_mx});

    logic                out_en_q;
    logic [BUS_W-1:0]    out_data_q;
    logic [1:0]          ser_cnt_q;
    logic [2*DATA_W-1:0] sv_q;

    // Emit H (or the packed word), then S and V on the following cycles.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            out_en_q   <= 1'b0;
            out_data_q <= '0;
            ser_cnt_q  <= 2'd0;
        end else if (div_vld) begin
            out_en_q   <= 1'b1;
            out_data_q <= first_word;
            ser_cnt_q  <= (SERIAL != 0) ? 2'd2 : 2'd0;
        end else if (ser_cnt_q != 2'd0) begin
            out_en_q   <= 1'b1;
            out_data_q <= BUS_W'(sv_q[2*DATA_W-1 -: DATA_W]);
            ser_cnt_q  <= ser_cnt_q - 2'd1;
        end else begin
            out_en_q   <= 1'b0;
            out_data_q <= '0;
        end
    end

    // S,V waiting to be shifted out behind H.
    always_ff @(posedge clk_sys) begin
        if (div_vld)                 sv_q <= {s_val, o_mx};
        else if (ser_cnt_q != 2'd0)  sv_q <= sv_q << DATA_W;
    end

    // ---------------- sync delay lines ----------------
    logic [SYNC_DLY-1:0] hs_q, vs_q;

    // Sync travels as long as the pixel data plus the serial S,V tail.
    always_ff @(posedge clk_sys) begin
        if (reset_sys) begin
            hs_q <= '0;
            vs_q <= '0;
        end else begin
            hs_q <= {hs_q[SYNC_DLY-2:0], InHSYNC};
            vs_q <= {vs_q[SYNC_DLY-2:0], InVSYNC};
        end
    end

    // Outputs read 0 for the whole time reset is held, not just after its first edge.
    assign OutEN    = out_en_q & ~reset_sys;
    assign Outdata  = reset_sys ? '0 : out_data_q;
    assign OutHSYNC = hs_q[SYNC_DLY-1] & ~reset_sys;
    assign OutVSYNC = vs_q[SYNC_DLY-1] & ~reset_sys;

`ifdef HSV_PIX_ERR_CHECK_EN
    logic pix_err_q;

    // Sticky flag for a sync cutting a serial pixel short; cleared per frame.
    always_ff @(posedge clk_sys) begin
        if (reset_sys)                                             pix_err_q <= 1'b0;
        else if ((SERIAL != 0) && sync && (byte_cnt_q != 2'd0))    pix_err_q <= 1'b1;
        else if (InVSYNC)                                          pix_err_q <= 1'b0;
    end

    assign pix_err = pix_err_q & ~reset_sys;
`else
    assign pix_err = 1'b0;
`endif

endmodule
